// File: rtl/memwb_pkg.sv
// Shared types and defaults for the MEM/WB skid stage.
package memwb_pkg;

  localparam int XLEN_DEF       = 32;
  localparam int REG_ADDR_W_DEF = 5;

  // Occupancy of the stage: nothing, main slot only, main plus skid
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } memwb_state_e;

  // Default-width payload as carried from MEM to WB
  typedef struct packed {
    logic [XLEN_DEF-1:0]       ReadData;
    logic [XLEN_DEF-1:0]       ALUOut;
    logic                      RegWrite;
    logic                      MemtoReg;
    logic [REG_ADDR_W_DEF-1:0] WriteReg;
  } memwb_payload_t;

  // Payload width for a given datapath / register-index width
  function automatic int payload_width(input int xlen, input int reg_addr_w);
    return 2 * xlen + reg_addr_w + 2;
  endfunction

endpackage

// File: rtl/memwb_slot.sv
// One payload-wide storage slot with load enable; clears to zero on reset.
module memwb_slot #(
  parameter int W = 73
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] data_d, data_q;

  // Next value: take new payload only when loaded
  always_comb begin
    data_d = data_q;
    if (ld) data_d = d;
  end

  // Storage register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign q = data_q;

endmodule

// File: rtl/memwb_skid_stage.sv
// MEM/WB pipeline register with valid/ready handshake, synchronous flush
// and a 2-entry skid buffer so ReadyM is a flop, never a path from ReadyW.
// Optional stall counter on StallCntW when MEMWB_STALL_CNT_EN is defined.
module memwb_skid_stage
  import memwb_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int CNT_W      = 16
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  FlushM,
  input  logic                  ValidM,
  output logic                  ReadyM,
  input  logic [XLEN-1:0]       RD,
  input  logic [XLEN-1:0]       ALUOutM,
  input  logic                  RegWriteM,
  input  logic                  MemtoRegM,
  input  logic [REG_ADDR_W-1:0] WriteRegM,
  output logic                  ValidW,
  input  logic                  ReadyW,
  output logic [XLEN-1:0]       ReadDataW,
  output logic [XLEN-1:0]       ALUOutW,
  output logic                  RegWriteW,
  output logic                  MemtoRegW,
  output logic [REG_ADDR_W-1:0] WriteRegW
`ifdef MEMWB_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]      StallCntW
`endif
);

  localparam int PW = payload_width(XLEN, REG_ADDR_W);

  typedef struct packed {
    logic [XLEN-1:0]       ReadData;
    logic [XLEN-1:0]       ALUOut;
    logic                  RegWrite;
    logic                  MemtoReg;
    logic [REG_ADDR_W-1:0] WriteReg;
  } payload_t;

  memwb_state_e state_d, state_q;
  logic         valid_d, valid_q;
  logic         ready_d, ready_q;
  logic         acc, ret;
  logic         main_ld, skid_ld, main_from_skid;
  payload_t     in_pl, main_pl, skid_pl, main_in;

  assign in_pl = '{ReadData: RD, ALUOut: ALUOutM, RegWrite: RegWriteM,
                   MemtoReg: MemtoRegM, WriteReg: WriteRegM};

  // Next state and slot loads; flush overrides every handshake
  always_comb begin
    acc            = ValidM & ready_q;
    ret            = valid_q & ReadyW;
    state_d        = state_q;
    main_ld        = 1'b0;
    skid_ld        = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      EMPTY: if (acc) begin
        state_d = FULL;
        main_ld = 1'b1;
      end
      FULL: begin
        if (acc && ret)  main_ld = 1'b1;
        else if (ret)    state_d = EMPTY;
        else if (acc) begin
          state_d = SKID;
          skid_ld = 1'b1;
        end
      end
      SKID: if (ret) begin
        // skid entry is older than anything upstream, so it moves up first
        state_d        = FULL;
        main_ld        = 1'b1;
        main_from_skid = 1'b1;
      end
      default: state_d = EMPTY;
    endcase
    if (FlushM) begin
      state_d = EMPTY;
      main_ld = 1'b0;
      skid_ld = 1'b0;
    end
    valid_d = (state_d != EMPTY);
    ready_d = (state_d != SKID);
    main_in = main_from_skid ? skid_pl : in_pl;
  end

  // State plus registered handshake outputs
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

  memwb_slot #(.W(PW)) u_main (
    .clk (CLK),
    .rst (Reset),
    .ld  (main_ld),
    .d   (main_in),
    .q   (main_pl)
  );

  memwb_slot #(.W(PW)) u_skid (
    .clk (CLK),
    .rst (Reset),
    .ld  (skid_ld),
    .d   (in_pl),
    .q   (skid_pl)
  );

  assign ReadyM    = ready_q;
  assign ValidW    = valid_q;
  assign ReadDataW = main_pl.ReadData;
  assign ALUOutW   = main_pl.ALUOut;
  assign RegWriteW = main_pl.RegWrite & valid_q;
  assign MemtoRegW = main_pl.MemtoReg;
  assign WriteRegW = main_pl.WriteReg;

`ifdef MEMWB_STALL_CNT_EN
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Saturating count of cycles where WB holds a valid transfer back
  always_comb begin
    cnt_d = cnt_q;
    if (valid_q && !ReadyW && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  // Counter register; only reset clears it
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign StallCntW = cnt_q;
`endif

endmodule

// File: tb/tb_memwb_skid_stage.sv
// Directed bench for memwb_skid_stage; stall-counter checks need
// MEMWB_STALL_CNT_EN defined for both bench and design.
module tb_memwb_skid_stage;

  localparam int XLEN = 32;
  localparam int RAW  = 5;
  localparam int CW   = 2;

  logic            CLK = 1'b0;
  logic            Reset, FlushM, ValidM, ReadyW;
  logic [XLEN-1:0] RD, ALUOutM;
  logic            RegWriteM, MemtoRegM;
  logic [RAW-1:0]  WriteRegM;
  logic            ReadyM, ValidW, RegWriteW, MemtoRegW;
  logic [XLEN-1:0] ReadDataW, ALUOutW;
  logic [RAW-1:0]  WriteRegW;
`ifdef MEMWB_STALL_CNT_EN
  logic [CW-1:0]   StallCntW;
`endif

  int errors = 0;
  int checks = 0;

  memwb_skid_stage #(.XLEN(XLEN), .REG_ADDR_W(RAW), .CNT_W(CW)) dut (
    .CLK(CLK), .Reset(Reset), .FlushM(FlushM), .ValidM(ValidM), .ReadyM(ReadyM),
    .RD(RD), .ALUOutM(ALUOutM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .WriteRegM(WriteRegM), .ValidW(ValidW), .ReadyW(ReadyW),
    .ReadDataW(ReadDataW), .ALUOutW(ALUOutW), .RegWriteW(RegWriteW),
    .MemtoRegW(MemtoRegW), .WriteRegW(WriteRegW)
`ifdef MEMWB_STALL_CNT_EN
    , .StallCntW(StallCntW)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock edge, outputs sampled 1 time unit later
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [XLEN-1:0] alu, input logic [XLEN-1:0] rd);
    ValidM  = 1'b1;
    ALUOutM = alu;
    RD      = rd;
  endtask

  initial begin
    Reset = 1'b1; FlushM = 1'b0; ValidM = 1'b0; ReadyW = 1'b0;
    RD = '0; ALUOutM = '0; RegWriteM = 1'b0; MemtoRegM = 1'b0; WriteRegM = '0;
    #12;
    chk("rst_valid", ValidW, 0);
    chk("rst_ready", ReadyM, 1);
    chk("rst_regwr", RegWriteW, 0);
    chk("rst_alu", ALUOutW, 0);
    chk("rst_rdata", ReadDataW, 0);
    chk("rst_wreg", WriteRegW, 0);
    @(negedge CLK); Reset = 1'b0;
    tick();

    // streaming at full rate
    ReadyW = 1'b1; RegWriteM = 1'b1; MemtoRegM = 1'b1; WriteRegM = 5'd7;
    for (int i = 1; i <= 4; i++) begin
      send(i, i * 32'h100);
      tick();
      chk("str_valid", ValidW, 1);
      chk("str_alu", ALUOutW, i);
      chk("str_rdata", ReadDataW, i * 32'h100);
      chk("str_ready", ReadyM, 1);
    end
    chk("str_regwr", RegWriteW, 1);
    chk("str_m2r", MemtoRegW, 1);
    chk("str_wreg", WriteRegW, 7);
    ValidM = 1'b0;
    tick();
    chk("str_drain", ValidW, 0);

    // bubble with RegWriteM high must not write
    RegWriteM = 1'b1;
    tick();
    chk("bub_valid", ValidW, 0);
    chk("bub_regwr", RegWriteW, 0);

    // back-pressure into skid
    ReadyW = 1'b0; WriteRegM = 5'd3; MemtoRegM = 1'b0;
    send(32'hA, 32'h1);
    tick();
    chk("bp1_alu", ALUOutW, 32'hA);
    chk("bp1_ready", ReadyM, 1);
    chk("bp1_regwr", RegWriteW, 1);
    send(32'hB, 32'h2);
    tick();
    chk("bp2_alu", ALUOutW, 32'hA);
    chk("bp2_ready", ReadyM, 0);
    send(32'hC, 32'h3);           // ignored while not ready
    tick();
    chk("bp3_alu", ALUOutW, 32'hA);
    chk("bp3_ready", ReadyM, 0);
    ValidM = 1'b0; ReadyW = 1'b1;
    tick();
    chk("bp4_valid", ValidW, 1);
    chk("bp4_alu", ALUOutW, 32'hB);
    chk("bp4_ready", ReadyM, 1);
    tick();
    chk("bp5_valid", ValidW, 0);

    // flush from SKID with an incoming transfer
    ReadyW = 1'b0;
    send(32'h11, 32'h5); tick();
    send(32'h22, 32'h6); tick();
    chk("fl_ready0", ReadyM, 0);
    FlushM = 1'b1; send(32'h33, 32'hDEAD);
    tick();
    chk("fl_valid", ValidW, 0);
    chk("fl_regwr", RegWriteW, 0);
    chk("fl_ready", ReadyM, 1);
    FlushM = 1'b0; ValidM = 1'b0;
    tick();
    chk("fl_nodead", ValidW, 0);
    // flush from FULL drops the same-cycle accept
    send(32'h44, 32'h7); tick();
    chk("fl2_full", ValidW, 1);
    FlushM = 1'b1; send(32'h55, 32'hDEAD);
    tick();
    chk("fl2_valid", ValidW, 0);
    FlushM = 1'b0; ValidM = 1'b0;
    ReadyW = 1'b1;
    tick();
    chk("fl2_nodead", ValidW, 0);

    // async reset while in SKID
    ReadyW = 1'b0;
    send(32'h66, 32'h8); tick();
    send(32'h77, 32'h9); tick();
    ValidM = 1'b0;
    chk("mrst_pre", ReadyM, 0);
    @(negedge CLK); #2 Reset = 1'b1; #1;
    chk("mrst_valid", ValidW, 0);
    chk("mrst_ready", ReadyM, 1);
    chk("mrst_regwr", RegWriteW, 0);
    chk("mrst_alu", ALUOutW, 0);
    chk("mrst_rdata", ReadDataW, 0);
    @(negedge CLK); Reset = 1'b0;

`ifdef MEMWB_STALL_CNT_EN
    // saturating stall counter, CNT_W=2
    chk("cnt_rst", StallCntW, 0);
    send(32'h88, 32'h0); tick();
    ValidM = 1'b0;
    chk("cnt_first", StallCntW, 0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("cnt_step", StallCntW, (i > 3) ? 3 : i);
    end
    FlushM = 1'b1; tick(); FlushM = 1'b0;
    chk("cnt_flush", StallCntW, 3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memwb_skid_stage.md
Name: memwb_skid_stage

Overview:
- Parametrised MEM/WB pipeline stage register for the pipelined MIPS core.
- Carries the memory-read result, ALU result, RegWrite, MemtoReg and destination register from MEM to WB.
- Adds a valid/ready handshake, synchronous flush and a 2-entry skid buffer, so that WB back-pressure (multi-cycle writeback, register-file port conflict) stalls MEM without losing a transfer and without a combinational ready path.
- Slots between data memory and the writeback mux/register file.

Parameters:
- XLEN, 32, width of ReadData/ALUOut datapaths.
- REG_ADDR_W, 5, width of destination register index.
- CNT_W, 16, width of stall counter (used only with the optional feature).

Ports:
- CLK  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- FlushM  input  1  synchronous flush; drops all held and incoming transfers.
- ValidM  input  1  MEM side presents a transfer.
- ReadyM  output  1  stage can accept; registered.
- RD  input  XLEN  data-memory read data.
- ALUOutM  input  XLEN  ALU result.
- RegWriteM  input  1  register-file write enable.
- MemtoRegM  input  1  writeback select.
- WriteRegM  input  REG_ADDR_W  destination register.
- ValidW  output  1  WB side transfer valid.
- ReadyW  input  1  WB consumes the transfer this cycle.
- ReadDataW  output  XLEN  held read data.
- ALUOutW  output  XLEN  held ALU result.
- RegWriteW  output  1  RegWrite gated by ValidW.
- MemtoRegW  output  1  held select.
- WriteRegW  output  REG_ADDR_W  held destination.
- StallCntW  output  CNT_W  stall counter (present only with MEMWB_STALL_CNT_EN).

Behaviour:
- Handshake events:
  - Accept (acc) = ValidM & ReadyM.
  - Retire (ret) = ValidW & ReadyW.
  - ValidW must not depend combinationally on ReadyW.
- Storage: main slot drives the W outputs; skid slot holds one overflow transfer.
- Reset (async, any time, including mid-transfer): ValidW=0, ReadyM=1, state EMPTY, all data/control registers 0, StallCntW=0.
- Latency: 1 cycle, ValidM sampled at edge N appears on ValidW after edge N. Sustains 1 transfer/cycle while ReadyW=1.
- State machine (ValidW = state!=EMPTY; ReadyM = state!=SKID, registered):
  - EMPTY:
    - acc -> FULL, main<=inputs.
  - FULL:
    - acc&ret -> FULL, main<=inputs.
    - ret only -> EMPTY.
    - acc only -> SKID, skid<=inputs.
    - neither -> hold.
  - SKID:
    - ReadyM=0, so no acc is possible.
    - ret -> FULL, main<=skid.
    - else hold.
- Ordering: strictly FIFO; the skid entry never overtakes main.
- FlushM=1 at an edge: next state EMPTY from any state, both slots invalidated, same-cycle input dropped. FlushM has priority over acc/ret. Data registers may retain stale values.
- RegWriteW = stored RegWrite & ValidW, so invalid or flushed bubbles never write the register file.
- All other outputs are undefined-but-stable when ValidW=0; the bench checks them only when ValidW=1.
- ValidM while ReadyM=0: ignored; upstream is required to hold its transfer.
- Simultaneous Reset and FlushM: Reset wins.

Optional Feature:
- Macro: MEMWB_STALL_CNT_EN.
- When defined:
  - StallCntW port exists.
  - Counts cycles with ValidW & ~ReadyW.
  - Saturates at 2^CNT_W-1; no wrap.
  - Cleared by Reset only; FlushM does not clear it.
- When undefined: port and counter are absent; no other behaviour changes.

Decomposition:
- Package memwb_pkg:
  - state enum {EMPTY, FULL, SKID} as 2-bit localparams.
  - Default XLEN/REG_ADDR_W constants.
  - Packed payload struct {ReadData, ALUOut, RegWrite, MemtoReg, WriteReg}, width XLEN*2+REG_ADDR_W+2.
- Sub-module memwb_slot: payload-wide register with async active-high reset and load enable, instantiated twice (main, skid). The FSM and ready/valid logic stay in the top module.

Test Plan:
- Reset mid-stream: Reset=1 while state=SKID -> same cycle ValidW=0, ReadyM=1, RegWriteW=0, all W data 0.
- Streaming: ReadyW=1, ValidM=1 for 4 cycles with ALUOutM=1,2,3,4 -> ALUOutW=1,2,3,4 on consecutive cycles starting 1 cycle later, ReadyM stays 1.
- Back-pressure into skid: hold ReadyW=0, send ALUOutM=0xA then 0xB -> ALUOutW=0xA, ReadyM=0 after 2nd edge. Release ReadyW -> 0xA then 0xB retire in order, ReadyM=1 again.
- Flush: state SKID, FlushM=1 with ValidM=1 and RD=0xDEAD -> next cycle ValidW=0, RegWriteW=0, and 0xDEAD never appears with ValidW=1.
- Bubble gating: ValidM=0 with RegWriteM=1 -> RegWriteW stays 0.
- MEMWB_STALL_CNT_EN with CNT_W=2: ValidW=1, ReadyW=0 for 5 cycles -> StallCntW 1,2,3,3,3.
